riscv_timer_periph: RTL and testbench
=====================================

Name: riscv_timer_periph

Overview:
- Memory-mapped timer/compare peripheral and responder on the core's data-memory bus (addr/wdata/be/we/re -> rdata), alongside data SRAM and GPIO.
- Top-level decode asserts bus_cs for window 0x0003_0000–0x0003_001F. Block decodes bus_addr[4:2] internally.
- Read data is registered (1-cycle latency), same timing as the data SRAM, so the top-level read mux treats both identically.
- Provides a prescaled 32-bit counter, compare match with optional auto-reload, level interrupt and PWM output.

Parameters:
- PRESC_W, 8, prescaler width; CTRL[15:8] holds the divider.
- CMP_RESET, 32'hFFFF_FFFF, reset value of COMPARE.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- bus_cs  input  1  window select from top-level decode
- bus_addr  input  5  byte address within window; [4:2] selects register, [1:0] ignored
- bus_wdata  input  32  write data
- bus_be  input  4  byte enables for writes
- bus_we  input  1  write strobe; effective only with bus_cs
- bus_re  input  1  read strobe; effective only with bus_cs
- bus_rdata  output  32  registered read data
- irq  output  1  level interrupt
- pwm_out  output  1  PWM output, high while COUNT < COMPARE and enabled

Interface: one clock (clk); reset is asynchronous and active-low (rst_n). All flops are reset by rst_n.

Behaviour:
- Register map (word index):
  - 0 CTRL: [0] EN, [1] AUTORELOAD, [2] IRQ_EN, [15:8] PRESC; other bits read 0.
  - 1 STATUS: [0] MATCH, [1] OVF; write-1-to-clear, per byte lane 0.
  - 2 COUNT: R/W.
  - 3 COMPARE: R/W.
  - 4–7: reserved. Writes are ignored; reads return 0.
- Reset values: CTRL=0, STATUS=0, COUNT=0, COMPARE=CMP_RESET, prescaler counter=0, bus_rdata=0, irq=0, pwm_out=0.
- Writes: on a clk edge with bus_cs&bus_we, each byte lane i is updated only where bus_be[i]=1. Written value is visible to a read issued the next cycle.
- Reads:
  - bus_cs&bus_re at edge N -> bus_rdata valid after edge N+1 and held until the next read.
  - Reads have no side effects.
  - If we and re are both asserted, the write occurs and the read returns the pre-write value.
- Prescaler:
  - When EN=1, presc_cnt increments each cycle.
  - When presc_cnt==PRESC, a tick is generated and presc_cnt returns to 0. PRESC=0 gives a tick every cycle.
  - When EN=0, presc_cnt is held at 0.
- Tick with EN=1:
  - If COUNT==COMPARE: MATCH<=1. COUNT<=0 if AUTORELOAD, else COUNT<=COUNT+1.
  - Else: COUNT<=COUNT+1. On wrap 0xFFFF_FFFF->0, OVF<=1.
  - Match with AUTORELOAD=0 and COMPARE=0xFFFF_FFFF sets both MATCH and OVF.
- Simultaneous events:
  - A bus write to COUNT in the same cycle as a tick: bus write wins, tick increment is discarded.
  - STATUS W1C in the same cycle as a hardware set of the same bit: set wins.
  - Writing PRESC does not reset presc_cnt. If the new PRESC < presc_cnt, presc_cnt counts up to 2^PRESC_W-1, wraps, and ticks when it next equals PRESC.
- irq: registered; irq <= MATCH & IRQ_EN (post-update values), one cycle after the flag sets.
- pwm_out: registered; pwm_out <= EN & (COUNT < COMPARE), unsigned compare.
- Reset mid-operation: asynchronous reset returns every flop to its reset value immediately. No pending write or read is preserved.

Decomposition:
- Package riscv_periph_pkg holds:
  - register word-offset constants (REG_CTRL=3'd0, REG_STATUS=3'd1, REG_COUNT=3'd2, REG_COMPARE=3'd3);
  - CTRL bit-position constants;
  - base-address constant 16'h0003 for the top-level decode.
- One natural sub-module: riscv_timer_prescaler (presc_cnt plus tick generation). Register file, counter and bus logic stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-count -> all registers, bus_rdata, irq and pwm_out read 0 except COMPARE=0xFFFF_FFFF; read of idx 3 after release returns 0xFFFF_FFFF.
- Byte-enable write: write COUNT=0xAABBCCDD be=4'b0101 over 0 -> read returns 0x00BB00DD, one cycle after re.
- Prescaled match, autoreload: COMPARE=3, PRESC=1, CTRL=0x0107 -> COUNT runs 0,1,2,3,0 with a tick every 2 cycles; MATCH=1 and irq=1 one cycle later; pwm_out high for 6 of each 8-cycle period.
- W1C vs set: write STATUS=0x1 in the exact match cycle -> MATCH remains 1; a second write clears it and irq drops the next cycle.
- Overflow: COUNT=0xFFFF_FFFE, COMPARE=0, PRESC=0, EN=1, AUTORELOAD=0 -> after two ticks COUNT=0 and OVF=1; MATCH sets on the following tick.
- Bus write vs tick: write COUNT=0x10 on a tick cycle -> next read returns 0x10, not 0x11; reserved idx 5 read returns 0.

Source files
------------

// File: rtl/riscv_periph_pkg.sv
// rtl/riscv_periph_pkg.sv - shared constants and helpers for the timer/compare peripheral
package riscv_periph_pkg;

    // Register word offsets, selected by bus_addr[4:2]
    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_COUNT   = 3'd2;
    localparam logic [2:0] REG_COMPARE = 3'd3;

    // CTRL bit positions
    localparam int CTRL_EN_BIT         = 0;
    localparam int CTRL_AUTORELOAD_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT     = 2;
    localparam int CTRL_PRESC_LSB      = 8;

    // STATUS bit positions
    localparam int STATUS_MATCH_BIT = 0;
    localparam int STATUS_OVF_BIT   = 1;

    // Upper address half matched by the top-level decode (window 0x0003_0000-0x0003_001F)
    localparam logic [15:0] TIMER_BASE_HI = 16'h0003;

    // Merge a bus write into an existing word, one byte lane per enable bit
    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/riscv_timer_prescaler.sv
// rtl/riscv_timer_prescaler.sv - prescaler counter producing one-cycle count ticks
// Ports: clk, rst_n (async, active-low); en holds the counter at 0 when low;
// presc is the terminal value; tick pulses while presc_cnt == presc and en is high.
module riscv_timer_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] presc_cnt_q;
    logic [PRESC_W-1:0] presc_cnt_d;

    // Equality (not >=) is deliberate: lowering presc below the running count
    // lets the counter wrap through 2^PRESC_W-1 before the next tick.
    assign tick = en && (presc_cnt_q == presc);

    always_comb begin
        presc_cnt_d = presc_cnt_q;
        if (!en) begin
            presc_cnt_d = '0;
        end else if (tick) begin
            presc_cnt_d = '0;
        end else begin
            presc_cnt_d = presc_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
        end
    end

endmodule

// File: rtl/riscv_timer_periph.sv
// rtl/riscv_timer_periph.sv - memory-mapped prescaled timer with compare, irq and PWM
// Ports: clk, rst_n (async, active-low); bus_cs/bus_addr/bus_wdata/bus_be/bus_we/bus_re
// data-memory bus slave with registered bus_rdata (1-cycle latency); irq level
// interrupt; pwm_out high while enabled and COUNT < COMPARE.
module riscv_timer_periph
    import riscv_periph_pkg::*;
#(
    parameter int          PRESC_W   = 8,
    parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_cs,
    input  logic [4:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_be,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [31:0] bus_rdata,
    output logic        irq,
    output logic        pwm_out
);

    // Only implemented CTRL bits are stored; everything else reads back as 0
    localparam logic [31:0] CTRL_MASK =
        ({{(32-PRESC_W){1'b0}}, {PRESC_W{1'b1}}} << CTRL_PRESC_LSB) | 32'h0000_0007;

    logic [31:0] ctrl_q, ctrl_d;
    logic        match_q, match_d;
    logic        ovf_q, ovf_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;
    logic        pwm_q, pwm_d;

    logic        wr_en;
    logic        rd_en;
    logic [2:0]  reg_idx;
    logic        tick;
    logic        unused_addr_lsb;

    assign wr_en           = bus_cs & bus_we;
    assign rd_en           = bus_cs & bus_re;
    assign reg_idx         = bus_addr[4:2];
    assign unused_addr_lsb = ^bus_addr[1:0];

    riscv_timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctrl_q[CTRL_EN_BIT]),
        .presc (ctrl_q[CTRL_PRESC_LSB +: PRESC_W]),
        .tick  (tick)
    );

    always_comb begin
        ctrl_d    = ctrl_q;
        match_d   = match_q;
        ovf_d     = ovf_q;
        count_d   = count_q;
        compare_d = compare_q;
        rdata_d   = rdata_q;

        // W1C goes first so a hardware set in the same cycle overrides the clear
        if (wr_en && (reg_idx == REG_STATUS) && bus_be[0]) begin
            if (bus_wdata[STATUS_MATCH_BIT]) match_d = 1'b0;
            if (bus_wdata[STATUS_OVF_BIT])   ovf_d   = 1'b0;
        end

        if (tick) begin
            if (count_q == compare_q) begin
                match_d = 1'b1;
            end
            if ((count_q == compare_q) && ctrl_q[CTRL_AUTORELOAD_BIT]) begin
                count_d = '0;
            end else begin
                count_d = count_q + 32'd1;
                if (count_q == 32'hFFFF_FFFF) ovf_d = 1'b1;
            end
        end

        // Bus writes come after the tick update so a COUNT write discards the increment
        if (wr_en) begin
            case (reg_idx)
                REG_CTRL:    ctrl_d    = apply_be(ctrl_q, bus_wdata, bus_be) & CTRL_MASK;
                REG_COUNT:   count_d   = apply_be(count_q, bus_wdata, bus_be);
                REG_COMPARE: compare_d = apply_be(compare_q, bus_wdata, bus_be);
                default:     ;
            endcase
        end

        // Reads sample pre-write state, so a combined we/re returns the old value
        if (rd_en) begin
            case (reg_idx)
                REG_CTRL:    rdata_d = ctrl_q;
                REG_STATUS:  rdata_d = {30'd0, ovf_q, match_q};
                REG_COUNT:   rdata_d = count_q;
                REG_COMPARE: rdata_d = compare_q;
                default:     rdata_d = '0;
            endcase
        end

        irq_d = match_d & ctrl_d[CTRL_IRQ_EN_BIT];
        pwm_d = ctrl_q[CTRL_EN_BIT] & (count_q < compare_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            match_q   <= 1'b0;
            ovf_q     <= 1'b0;
            count_q   <= '0;
            compare_q <= CMP_RESET;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            match_q   <= match_d;
            ovf_q     <= ovf_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
            pwm_q     <= pwm_d;
        end
    end

    assign bus_rdata = rdata_q;
    assign irq       = irq_q;
    assign pwm_out   = pwm_q;

endmodule

// File: tb/tb_riscv_timer_periph.sv
// tb/tb_riscv_timer_periph.sv - directed self-checking bench for riscv_timer_periph
module tb_riscv_timer_periph;

    logic        clk;
    logic        rst_n;
    logic        bus_cs;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_rdata;
    logic        irq;
    logic        pwm_out;

    int tests;
    int fails;
    int pwm_hi;
    logic [31:0] exp_q[$];

    riscv_timer_periph dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_cs    (bus_cs),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_be    (bus_be),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_rdata (bus_rdata),
        .irq       (irq),
        .pwm_out   (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus_cs = 1'b0; bus_we = 1'b0; bus_re = 1'b0;
        bus_addr = '0; bus_wdata = '0; bus_be = '0;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] be);
        logic [1:0] lsb;
        lsb = 2'($urandom_range(0, 3));
        bus_cs = 1'b1; bus_we = 1'b1; bus_re = 1'b0;
        bus_addr = {idx, lsb}; bus_wdata = data; bus_be = be;
        @(posedge clk); #1;
        idle_bus();
    endtask

    // Issue a read, queue its expected value, compare once the registered data appears
    task automatic rd(input logic [2:0] idx, input logic [31:0] exp, input string tag);
        logic [1:0] lsb;
        lsb = 2'($urandom_range(0, 3));
        bus_cs = 1'b1; bus_re = 1'b1; bus_we = 1'b0;
        bus_addr = {idx, lsb}; bus_be = 4'hF; bus_wdata = 32'hDEAD_BEEF;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        idle_bus();
        check(tag, bus_rdata, exp_q.pop_front());
    endtask

    task automatic rw(input logic [2:0] idx, input logic [31:0] data, input logic [31:0] exp,
                      input string tag);
        bus_cs = 1'b1; bus_re = 1'b1; bus_we = 1'b1;
        bus_addr = {idx, 2'b00}; bus_be = 4'hF; bus_wdata = data;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        idle_bus();
        check(tag, bus_rdata, exp_q.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; fails = 0; pwm_hi = 0;
        idle_bus();
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(posedge clk); #1;
        check("reset_rdata", bus_rdata, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        check("reset_pwm", {31'd0, pwm_out}, 32'h0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        rd(3'd0, 32'h0, "reset_ctrl");
        rd(3'd1, 32'h0, "reset_status");
        rd(3'd2, 32'h0, "reset_count");
        rd(3'd3, 32'hFFFF_FFFF, "reset_compare");

        // Byte-enable write
        wr(3'd2, 32'hAABB_CCDD, 4'b0101);
        rd(3'd2, 32'h00BB_00DD, "be_write_count");

        // Simultaneous write/read returns the pre-write value; CTRL masks unused bits
        rw(3'd3, 32'h1234_5678, 32'hFFFF_FFFF, "rw_pre_write");
        rd(3'd3, 32'h1234_5678, "rw_post_write");
        wr(3'd0, 32'hFFFF_FFF8, 4'hF);
        rd(3'd0, 32'h0000_FF00, "ctrl_mask");
        wr(3'd0, 32'h0, 4'hF);

        // Prescaled match with autoreload: ticks on every second edge after enable
        wr(3'd2, 32'h0, 4'hF);
        wr(3'd3, 32'h3, 4'hF);
        wr(3'd0, 32'h0000_0107, 4'hF);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (pwm_out) pwm_hi++;
            if (k == 7) check("irq_before_match", {31'd0, irq}, 32'h0);
            if (k == 8) check("irq_at_match", {31'd0, irq}, 32'h1);
        end
        check("pwm_high_cycles", pwm_hi, 32'd12);
        rd(3'd1, 32'h1, "status_match");

        // W1C in the exact match cycle: set wins
        repeat (6) @(posedge clk); #1;
        wr(3'd1, 32'h1, 4'h1);
        check("irq_after_w1c_race", {31'd0, irq}, 32'h1);
        rd(3'd1, 32'h1, "match_survives_w1c");
        wr(3'd1, 32'h1, 4'h1);
        check("irq_after_clear", {31'd0, irq}, 32'h0);
        rd(3'd1, 32'h0, "match_cleared");
        wr(3'd0, 32'h0, 4'hF);

        // Overflow without autoreload, PRESC=0
        wr(3'd1, 32'h3, 4'h1);
        wr(3'd2, 32'hFFFF_FFFE, 4'hF);
        wr(3'd3, 32'h0, 4'hF);
        wr(3'd0, 32'h0000_0001, 4'hF);
        rd(3'd2, 32'hFFFF_FFFE, "ovf_count0");
        rd(3'd2, 32'hFFFF_FFFF, "ovf_count1");
        rd(3'd1, 32'h2, "ovf_flag_only");
        rd(3'd2, 32'h1, "count_after_match");
        rd(3'd1, 32'h3, "ovf_and_match");

        // Bus write beats tick; reserved registers
        wr(3'd0, 32'h0000_0005, 4'hF);
        wr(3'd3, 32'h0000_1000, 4'hF);
        wr(3'd2, 32'h0000_0010, 4'hF);
        rd(3'd2, 32'h0000_0010, "write_beats_tick");
        rd(3'd5, 32'h0, "reserved5_read");
        wr(3'd5, 32'hFFFF_FFFF, 4'hF);
        rd(3'd5, 32'h0, "reserved5_after_write");
        rd(3'd7, 32'h0, "reserved7_read");
        rd(3'd0, 32'h0000_0005, "ctrl_readback");
        check("irq_enabled_match", {31'd0, irq}, 32'h1);
        check("pwm_running", {31'd0, pwm_out}, 32'h1);

        // Asynchronous reset mid-count
        #2 rst_n = 1'b0;
        #1;
        check("midreset_rdata", bus_rdata, 32'h0);
        check("midreset_irq", {31'd0, irq}, 32'h0);
        check("midreset_pwm", {31'd0, pwm_out}, 32'h0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        rd(3'd0, 32'h0, "post_reset_ctrl");
        rd(3'd1, 32'h0, "post_reset_status");
        rd(3'd2, 32'h0, "post_reset_count");
        rd(3'd3, 32'hFFFF_FFFF, "post_reset_compare");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
